// File: rtl/multicycle_core.sv
// Two-state-per-instruction RV32I subset core: FETCH waits for imem_ready, EXEC commits,
// HALT is terminal until reset. dbg_rdata gives a combinational register-file read.
module multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          NREG     = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  halt_code,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
);
    localparam int AW = $clog2(NREG);

    localparam logic [6:0]  OPC_LUI     = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0]  OPC_JAL     = 7'b1101111;
    localparam logic [6:0]  OPC_JALR    = 7'b1100111;
    localparam logic [6:0]  OPC_IMM     = 7'b0010011;
    localparam logic [6:0]  OPC_REG     = 7'b0110011;
    localparam logic [6:0]  OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0]  F7_BASE     = 7'b0000000;
    localparam logic [6:0]  F7_ALT      = 7'b0100000;
    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_e;
    typedef enum logic [1:0] {
        HC_RUN      = 2'b00,
        HC_EBREAK   = 2'b01,
        HC_ILLEGAL  = 2'b10,
        HC_MISALIGN = 2'b11
    } halt_e;

    state_e      state_q, state_d;
    halt_e       halt_code_q, halt_code_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] regs_q [NREG];
    logic        rf_we;

    function automatic logic reg_ok(input logic [4:0] idx);
        return {1'b0, idx} < 6'(NREG);
    endfunction

    function automatic logic [31:0] reg_read(input logic [4:0] idx);
        if (!reg_ok(idx)) return 32'h0;
        return regs_q[idx[AW-1:0]];
    endfunction

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_u, imm_j, rs1_val, rs2_val, pc_plus4;

    assign opcode   = ir_q[6:0];
    assign rd       = ir_q[11:7];
    assign funct3   = ir_q[14:12];
    assign rs1      = ir_q[19:15];
    assign rs2      = ir_q[24:20];
    assign funct7   = ir_q[31:25];
    assign imm_i    = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_u    = {ir_q[31:12], 12'h000};
    assign imm_j    = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign rs1_val  = reg_read(rs1);
    assign rs2_val  = reg_read(rs2);
    assign pc_plus4 = pc_q + 32'd4;

    // ALU shared by OP and OP-IMM; the immediate path reuses imm_i[4:0] as shamt.
    logic [31:0] alu_b, alu_res, sra_res;
    assign alu_b   = (opcode == OPC_REG) ? rs2_val : imm_i;
    assign sra_res = $signed(rs1_val) >>> alu_b[4:0];

    always_comb begin
        case (funct3)
            3'b000:  alu_res = (opcode == OPC_REG && funct7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_res = rs1_val << alu_b[4:0];
            3'b010:  alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_res = {31'b0, rs1_val < alu_b};
            3'b100:  alu_res = rs1_val ^ alu_b;
            3'b101:  alu_res = funct7[5] ? sra_res : rs1_val >> alu_b[4:0];
            3'b110:  alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    logic        use_rd, use_rs1, use_rs2, legal, is_ebreak, is_jump;
    logic [31:0] wb_val, jump_tgt;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        use_rd    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        legal     = 1'b1;
        is_ebreak = 1'b0;
        is_jump   = 1'b0;
        wb_val    = alu_res;
        jump_tgt  = pc_q + imm_j;
        case (opcode)
            OPC_LUI: begin
                use_rd = 1'b1;
                wb_val = imm_u;
            end
            OPC_AUIPC: begin
                use_rd = 1'b1;
                wb_val = pc_q + imm_u;
            end
            OPC_JAL: begin
                use_rd  = 1'b1;
                is_jump = 1'b1;
                wb_val  = pc_plus4;
            end
            OPC_JALR: begin
                use_rd   = 1'b1;
                use_rs1  = 1'b1;
                is_jump  = 1'b1;
                wb_val   = pc_plus4;
                jump_tgt = (rs1_val + imm_i) & ~32'd1;
                legal    = (funct3 == 3'b000);
            end
            OPC_IMM: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                case (funct3)
                    3'b001:  legal = (funct7 == F7_BASE);
                    3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    default: legal = 1'b1;
                endcase
            end
            OPC_REG: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                legal   = (funct7 == F7_BASE) ||
                          (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OPC_SYSTEM: begin
                legal     = (ir_q == EBREAK_INSN);
                is_ebreak = legal;
            end
            default: legal = 1'b0;
        endcase
        if ((use_rd && !reg_ok(rd)) || (use_rs1 && !reg_ok(rs1)) || (use_rs2 && !reg_ok(rs2)))
            legal = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        halt_code_d = halt_code_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        rf_we       = 1'b0;
        imem_req    = 1'b0;
        retire      = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = !rst;
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!legal) begin
                    state_d     = S_HALT;
                    halt_code_d = HC_ILLEGAL;
                end else if (is_ebreak) begin
                    state_d     = S_HALT;
                    halt_code_d = HC_EBREAK;
                end else if (is_jump && jump_tgt[1]) begin
                    state_d     = S_HALT;
                    halt_code_d = HC_MISALIGN;
                end else begin
                    rf_we   = use_rd && (rd != 5'd0);
                    retire  = !rst;
                    pc_d    = is_jump ? jump_tgt : pc_plus4;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            halt_code_q <= HC_RUN;
            pc_q        <= RESET_PC;
            ir_q        <= 32'h0;
            // NOTE: the register file is architecturally cleared by reset, so it is built from flops.
            for (int i = 0; i < NREG; i++) regs_q[i] <= 32'h0;
        end else begin
            state_q     <= state_d;
            halt_code_q <= halt_code_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            if (rf_we) regs_q[rd[AW-1:0]] <= wb_val;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign halted    = (state_q == S_HALT);
    assign halt_code = halt_code_q;
    assign dbg_rdata = reg_read(dbg_raddr);
endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000: PC loaded on reset.
REQ-002 SHALL have parameter NREG, default 32: register count; legal values 16 (RV32E) or 32.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_req  output  1  fetch request.
REQ-006 SHALL have port imem_addr  output  32  fetch address, equal to pc.
REQ-007 SHALL have port imem_ready  input  1  fetch data valid this cycle.
REQ-008 SHALL have port imem_rdata  input  32  fetched instruction.
REQ-009 SHALL have port pc  output  32  address of the current instruction.
REQ-010 SHALL have port retire  output  1  one-cycle pulse per committed instruction.
REQ-011 SHALL have port halted  output  1  core stopped.
REQ-012 SHALL have port halt_code  output  2  00 running, 01 EBREAK, 10 illegal instruction, 11 misaligned jump target.
REQ-013 SHALL have port dbg_raddr  input  5  debug register index.
REQ-014 SHALL have port dbg_rdata  output  32  combinational register read; 0 for x0 or index >= NREG.

Function
REQ-015 SHALL implement a three-state FSM: FETCH, EXEC, HALT.
REQ-016 FETCH: imem_req=1 and imem_addr=pc, held stable until imem_ready=1; on that edge latch imem_rdata into the instruction register and go to EXEC.
REQ-017 EXEC: decode, compute, write rd, update pc, pulse retire, return to FETCH; imem_req=0 in EXEC. Minimum 2 cycles per instruction.
REQ-018 SHALL execute LUI, AUIPC, JAL, JALR, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA, EBREAK per RV32I semantics.
REQ-019 Immediates SHALL be sign-extended to 32 bits per I/U/J format; LUI writes imm<<12; AUIPC writes pc+(imm<<12).
REQ-020 JAL/JALR SHALL write pc+4 to rd; JALR target = (rs1+imm) with bit 0 cleared.
REQ-021 All arithmetic, including pc+4 and branch targets, SHALL wrap modulo 2^32.
REQ-022 Register shifts SHALL use rs2[4:0]; immediate shifts use imm[4:0]; SRAI/SRA require funct7=0100000, SLLI/SRLI funct7=0000000, else illegal.
REQ-023 x0 SHALL read 0; writes with rd=0 SHALL be discarded.
REQ-024 Any opcode/funct combination outside REQ-018, or any rs1/rs2/rd index >= NREG, SHALL enter HALT with halt_code=10.
REQ-025 A JAL/JALR target with bit 1 set SHALL enter HALT with halt_code=11; no rd write, pc unchanged.
REQ-026 EBREAK SHALL enter HALT with halt_code=01; pc unchanged.
REQ-027 Halting instructions SHALL NOT pulse retire and SHALL NOT write any register.
REQ-028 HALT SHALL be terminal until reset: halted=1, imem_req=0, imem_ready ignored.
REQ-029 imem_ready asserted outside FETCH SHALL be ignored.
REQ-030 A read of the register written in the previous EXEC SHALL return the new value (write lands at end of EXEC).

Reset
REQ-031 While rst=1: state=FETCH, pc=RESET_PC, all registers=0, imem_req=0, retire=0, halted=0, halt_code=00.
REQ-032 Reset asserted mid-fetch or mid-EXEC SHALL abort immediately; any in-flight imem_ready is discarded; no register write or retire occurs.
REQ-033 First imem_req=1 SHALL appear in the first cycle after rst deasserts.

Verification
REQ-034 Reset release, imem_ready held 0 for 5 cycles -> imem_req=1, imem_addr=32'h8000_0000 stable all 5 cycles, retire=0.
REQ-035 ADDI x1,x0,-1 then SLTIU x2,x1,1 -> dbg x1=32'hFFFF_FFFF, x2=0, two retire pulses, pc=32'h8000_0008.
REQ-036 LUI x3,0x12345; ADDI x3,x3,0x678; SRAI x4,x3,4 -> x3=32'h1234_5678, x4=32'h0123_4567.
REQ-037 JAL x1,+8 at 32'h8000_0000 -> x1=32'h8000_0004, next imem_addr=32'h8000_0008; JALR to target 32'h8000_0102 -> halted=1, halt_code=11, x rd unchanged.
REQ-038 NREG=16, ADD x20,x1,x2 -> halted=1, halt_code=10, no retire; EBREAK in NREG=32 build -> halt_code=01, pc holds EBREAK address.
REQ-039 rst pulsed while imem_ready=1 in FETCH after executing ADDI x5,x0,7 -> x5=0, pc=RESET_PC, no retire.
